// File: rtl/rot_matrix_cordic_if.sv
// Request/result bus of the tilt rotation-matrix generator: angle pair in, nine
// matrix terms plus clamp flag out.
interface rot_matrix_cordic_if #(
  parameter int ANGLE_W = 13,
  parameter int OUT_W   = 18
);
  logic                      validIn;
  logic                      readyIn;
  logic signed [ANGLE_W-1:0] Rx;
  logic signed [ANGLE_W-1:0] Ry;
  logic signed [OUT_W-1:0]   R11, R12, R13;
  logic signed [OUT_W-1:0]   R21, R22, R23;
  logic signed [OUT_W-1:0]   R31, R32, R33;
  logic                      validOut;
  logic                      sat;

  modport master (
    output validIn, Rx, Ry,
    input  readyIn, R11, R12, R13, R21, R22, R23, R31, R32, R33, validOut, sat
  );

  modport slave (
    input  validIn, Rx, Ry,
    output readyIn, R11, R12, R13, R21, R22, R23, R31, R32, R33, validOut, sat
  );
endinterface

// File: rtl/rot_matrix_cordic.sv
// R = Ry*Rx from two tilt angles using one time-shared iterative CORDIC over Rx, Ry, Ry+Rx, Ry-Rx.
// Optional input clamp to +/-LIMIT with sat flag when ROTM_CLAMP_EN is defined.
module rot_matrix_cordic #(
  parameter int ANGLE_W = 13,
  parameter int OUT_W   = 18,
  parameter int ITER    = 16,
  parameter int LIMIT   = 536
) (
  input  logic              clock,
  input  logic              reset,
  rot_matrix_cordic_if.slave bus
);
  localparam int XW   = OUT_W + 2;
  localparam int AW   = ANGLE_W + 1;
  localparam int ZSH  = 29 - (ANGLE_W - 3);

  typedef logic signed [OUT_W-1:0] out_t;
  typedef logic signed [XW-1:0]    xy_t;
  typedef logic signed [AW-1:0]    ang_t;

  localparam out_t OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam out_t OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam xy_t  K_INIT  = XW'($rtoi(0.6072529 * (2.0 ** (OUT_W-2)) + 0.5));

  // atan(2^-i) in Q3.29
  localparam logic signed [31:0] ATAN [16] = '{
    32'sd421657428, 32'sd248918915, 32'sd131521918, 32'sd66762579,
    32'sd33510843,  32'sd16771758,  32'sd8387925,   32'sd4194219,
    32'sd2097141,   32'sd1048575,   32'sd524288,    32'sd262144,
    32'sd131072,    32'sd65536,     32'sd32768,     32'sd16384
  };

  typedef enum logic [1:0] {IDLE, LOAD, ROTATE, COMBINE} state_t;

  function automatic out_t sat_out(input xy_t v);
    if (v[XW-1:OUT_W-1] == '0 || v[XW-1:OUT_W-1] == '1) return v[OUT_W-1:0];
    return v[XW-1] ? OUT_MIN : OUT_MAX;
  endfunction

  function automatic out_t half_add(input out_t a, input out_t b);
    logic signed [OUT_W:0] t;
    t = {a[OUT_W-1], a} + {b[OUT_W-1], b};
    return t[OUT_W:1];
  endfunction

  function automatic out_t half_sub(input out_t a, input out_t b);
    logic signed [OUT_W:0] t;
    t = {a[OUT_W-1], a} - {b[OUT_W-1], b};
    return t[OUT_W:1];
  endfunction

  function automatic out_t neg_sat(input out_t a);
    if (a == OUT_MIN) return OUT_MAX;
    return -a;
  endfunction

  state_t                    state;
  logic [1:0]                k;
  logic [3:0]                it;
  xy_t                       x, y;
  logic signed [31:0]        z;
  logic signed [ANGLE_W-1:0] rx_q, ry_q;
  ang_t                      sum_q, diff_q;
  logic                      sat_q;
  out_t                      cos_rx, sin_rx, cos_ry, sin_ry, cos_sum, sin_sum;

  logic signed [ANGLE_W-1:0] rx_c, ry_c;
  logic                      clip;

`ifdef ROTM_CLAMP_EN
  localparam logic signed [ANGLE_W-1:0] LIM_P = ANGLE_W'(LIMIT);
  localparam logic signed [ANGLE_W-1:0] LIM_N = -LIM_P;

  always_comb begin
    rx_c = bus.Rx;
    ry_c = bus.Ry;
    if (bus.Rx > LIM_P)      rx_c = LIM_P;
    else if (bus.Rx < LIM_N) rx_c = LIM_N;
    if (bus.Ry > LIM_P)      ry_c = LIM_P;
    else if (bus.Ry < LIM_N) ry_c = LIM_N;
    clip = (rx_c != bus.Rx) || (ry_c != bus.Ry);
  end
`else
  assign rx_c = bus.Rx;
  assign ry_c = bus.Ry;
  assign clip = 1'b0;
`endif

  ang_t               ang;
  logic signed [31:0] z_ext, z_init;

  always_comb begin
    case (k)
      2'd0:    ang = {rx_q[ANGLE_W-1], rx_q};
      2'd1:    ang = {ry_q[ANGLE_W-1], ry_q};
      2'd2:    ang = sum_q;
      default: ang = diff_q;
    endcase
  end

  assign z_ext  = 32'(ang);
  assign z_init = z_ext <<< ZSH;

  xy_t  xs, ys, xn, yn;
  logic signed [31:0] zn;
  logic z_pos, last;
  out_t cos_new, sin_new;

  assign xs      = x >>> it;
  assign ys      = y >>> it;
  assign z_pos   = ~z[31];
  assign xn      = z_pos ? x - ys : x + ys;
  assign yn      = z_pos ? y + xs : y - xs;
  assign zn      = z_pos ? z - ATAN[it] : z + ATAN[it];
  assign last    = (it == 4'(ITER-1));
  assign cos_new = sat_out(xn);
  assign sin_new = sat_out(yn);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      k            <= '0;
      it           <= '0;
      x            <= '0;
      y            <= '0;
      z            <= '0;
      rx_q         <= '0;
      ry_q         <= '0;
      sum_q        <= '0;
      diff_q       <= '0;
      sat_q        <= 1'b0;
      cos_rx       <= '0;
      sin_rx       <= '0;
      cos_ry       <= '0;
      sin_ry       <= '0;
      cos_sum      <= '0;
      sin_sum      <= '0;
      bus.readyIn  <= 1'b1;
      bus.validOut <= 1'b0;
      bus.sat      <= 1'b0;
      bus.R11      <= '0;
      bus.R12      <= '0;
      bus.R13      <= '0;
      bus.R21      <= '0;
      bus.R22      <= '0;
      bus.R23      <= '0;
      bus.R31      <= '0;
      bus.R32      <= '0;
      bus.R33      <= '0;
    end else begin
      bus.validOut <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.validIn && bus.readyIn) begin
            rx_q        <= rx_c;
            ry_q        <= ry_c;
            sum_q       <= {ry_c[ANGLE_W-1], ry_c} + {rx_c[ANGLE_W-1], rx_c};
            diff_q      <= {ry_c[ANGLE_W-1], ry_c} - {rx_c[ANGLE_W-1], rx_c};
            sat_q       <= clip;
            k           <= '0;
            bus.readyIn <= 1'b0;
            state       <= LOAD;
          end
        end
        LOAD: begin
          x     <= K_INIT;
          y     <= '0;
          z     <= z_init;
          it    <= '0;
          state <= ROTATE;
        end
        ROTATE: begin
          x  <= xn;
          y  <= yn;
          z  <= zn;
          it <= it + 4'd1;
          if (last) begin
            k <= k + 2'd1;
            case (k)
              2'd0: begin cos_rx  <= cos_new; sin_rx  <= sin_new; end
              2'd1: begin cos_ry  <= cos_new; sin_ry  <= sin_new; end
              2'd2: begin cos_sum <= cos_new; sin_sum <= sin_new; end
              default: ;
            endcase
            if (k == 2'd3) begin
              // DIFF terms come straight off the final micro-rotation so the
              // result is registered on the edge that enters COMBINE.
              bus.R11      <= cos_ry;
              bus.R12      <= half_sub(cos_new, cos_sum);
              bus.R13      <= half_add(sin_sum, sin_new);
              bus.R21      <= '0;
              bus.R22      <= cos_rx;
              bus.R23      <= neg_sat(sin_rx);
              bus.R31      <= neg_sat(sin_ry);
              bus.R32      <= half_sub(sin_sum, sin_new);
              bus.R33      <= half_add(cos_sum, cos_new);
              bus.sat      <= sat_q;
              bus.validOut <= 1'b1;
              state        <= COMBINE;
            end else begin
              state <= LOAD;
            end
          end
        end
        COMBINE: begin
          bus.readyIn <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rot_matrix_cordic.sv
// Directed bench for rot_matrix_cordic: latency, matrix values, clamp, back-to-back, mid-run reset.
module tb_rot_matrix_cordic;
  localparam int TOL = 16;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  string nm [9] = '{"R11","R12","R13","R21","R22","R23","R31","R32","R33"};

  always #5 clock = ~clock;

  rot_matrix_cordic_if #(.ANGLE_W(13), .OUT_W(18)) bus();

  rot_matrix_cordic #(.ANGLE_W(13), .OUT_W(18), .ITER(16), .LIMIT(536)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  task automatic read_r(output int r[9]);
    r[0] = int'(bus.R11); r[1] = int'(bus.R12); r[2] = int'(bus.R13);
    r[3] = int'(bus.R21); r[4] = int'(bus.R22); r[5] = int'(bus.R23);
    r[6] = int'(bus.R31); r[7] = int'(bus.R32); r[8] = int'(bus.R33);
  endtask

  // One transfer from IDLE; lat is the cycle validOut is seen in, -1 on timeout.
  task automatic run_one(input int rx, input int ry, output int lat);
    @(negedge clock);
    bus.Rx = 13'(rx); bus.Ry = 13'(ry); bus.validIn = 1'b1;
    @(posedge clock);
    #1 bus.validIn = 1'b0;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      if (bus.validOut) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    int r[9];
    reset = 1'b1;
    bus.validIn = 1'b0; bus.Rx = '0; bus.Ry = '0;
    repeat (3) @(negedge clock);
    read_r(r);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (r[i] !== 0) begin failures++; $display("FAIL reset_%s actual=%0d expected=0", nm[i], r[i]); end
    end
    checks++;
    if (bus.readyIn !== 1'b1) begin failures++; $display("FAIL reset_readyIn actual=%b expected=1", bus.readyIn); end
    checks++;
    if (bus.validOut !== 1'b0) begin failures++; $display("FAIL reset_validOut actual=%b expected=0", bus.validOut); end
    checks++;
    if (bus.sat !== 1'b0) begin failures++; $display("FAIL reset_sat actual=%b expected=0", bus.sat); end
    reset = 1'b0;
  endtask

  task automatic test_zero();
    int lat; int r[9]; int e[9];
    e = '{65536, 0, 0, 0, 65536, 0, 0, 0, 65536};
    run_one(0, 0, lat);
    checks++;
    if (lat !== 69) begin failures++; $display("FAIL zero_latency actual=%0d expected=69", lat); end
    read_r(r);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (r[i] < e[i] - TOL || r[i] > e[i] + TOL) begin
        failures++; $display("FAIL zero_%s actual=%0d expected=%0d+-%0d", nm[i], r[i], e[i], TOL);
      end
    end
    checks++;
    if (r[3] !== 0) begin failures++; $display("FAIL zero_R21_exact actual=%0d expected=0", r[3]); end
    checks++;
    if (bus.sat !== 1'b0) begin failures++; $display("FAIL zero_sat actual=%b expected=0", bus.sat); end
    checks++;
    if (bus.readyIn !== 1'b0) begin failures++; $display("FAIL zero_ready_busy actual=%b expected=0", bus.readyIn); end
    @(negedge clock);
    checks++;
    if (bus.validOut !== 1'b0 || bus.readyIn !== 1'b1) begin
      failures++; $display("FAIL zero_pulse_end validOut=%b readyIn=%b expected 0/1", bus.validOut, bus.readyIn);
    end
  endtask

  task automatic test_rx();
    int lat; int r[9]; int e[9];
    e = '{65536, 0, 0, 0, 56761, -32759, 0, 32759, 56761};
    run_one(536, 0, lat);
    checks++;
    if (lat !== 69) begin failures++; $display("FAIL rx_latency actual=%0d expected=69", lat); end
    read_r(r);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (r[i] < e[i] - TOL || r[i] > e[i] + TOL) begin
        failures++; $display("FAIL rx_%s actual=%0d expected=%0d+-%0d", nm[i], r[i], e[i], TOL);
      end
    end
    checks++;
    if (bus.sat !== 1'b0) begin failures++; $display("FAIL rx_sat actual=%b expected=0", bus.sat); end
  endtask

  task automatic test_ry();
    int lat; int r[9]; int e[9];
    e = '{56761, 0, -32759, 0, 65536, 0, 32759, 0, 56761};
    run_one(0, -536, lat);
    checks++;
    if (lat !== 69) begin failures++; $display("FAIL ry_latency actual=%0d expected=69", lat); end
    read_r(r);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (r[i] < e[i] - TOL || r[i] > e[i] + TOL) begin
        failures++; $display("FAIL ry_%s actual=%0d expected=%0d+-%0d", nm[i], r[i], e[i], TOL);
      end
    end
  endtask

  task automatic test_clamp();
    int lat; int r[9]; int e[9];
    e = '{56761, -16375, -28373, 0, 56761, -32759, 32759, 28373, 49161};
    run_one(1000, -2000, lat);
    checks++;
    if (lat !== 69) begin failures++; $display("FAIL clamp_latency actual=%0d expected=69", lat); end
    read_r(r);
`ifdef ROTM_CLAMP_EN
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (r[i] < e[i] - TOL || r[i] > e[i] + TOL) begin
        failures++; $display("FAIL clamp_%s actual=%0d expected=%0d+-%0d", nm[i], r[i], e[i], TOL);
      end
    end
    checks++;
    if (bus.sat !== 1'b1) begin failures++; $display("FAIL clamp_sat actual=%b expected=1", bus.sat); end
`else
    checks++;
    if (bus.sat !== 1'b0) begin failures++; $display("FAIL clamp_sat actual=%b expected=0", bus.sat); end
`endif
  endtask

  task automatic test_back_to_back();
    int vals[3];
    int cap[$];
    int prev, nres, v, e22, e23, a22, a23;
    vals = '{0, 536, -536};
    prev = -1; nres = 0;
    for (int c = 0; c < 282; c++) begin
      @(negedge clock);
      if (bus.validOut) begin
        nres++;
        if (prev >= 0) begin
          checks++;
          if (c - prev !== 70) begin failures++; $display("FAIL b2b_spacing actual=%0d expected=70", c - prev); end
        end
        prev = c;
        checks++;
        if (cap.size() == 0) begin
          failures++; $display("FAIL b2b_orphan result at step %0d with no capture", c);
        end else begin
          v = cap.pop_front();
          if (v == 0)        begin e22 = 65536; e23 = 0;      end
          else if (v == 536) begin e22 = 56761; e23 = -32759; end
          else               begin e22 = 56761; e23 = 32759;  end
          a22 = int'(bus.R22); a23 = int'(bus.R23);
          if (a22 < e22 - TOL || a22 > e22 + TOL || a23 < e23 - TOL || a23 > e23 + TOL) begin
            failures++;
            $display("FAIL b2b_value Rx=%0d R22=%0d R23=%0d expected %0d/%0d+-%0d", v, a22, a23, e22, e23, TOL);
          end
        end
      end
      if (c < 211) begin
        v = vals[c % 3];
        bus.Rx = 13'(v); bus.Ry = '0; bus.validIn = 1'b1;
        if (bus.readyIn) cap.push_back(v);
      end else begin
        bus.validIn = 1'b0;
      end
    end
    checks++;
    if (nres !== 4) begin failures++; $display("FAIL b2b_count actual=%0d expected=4", nres); end
  endtask

  task automatic test_reset_mid();
    int lat; int r[9]; int e[9];
    logic seen;
    @(negedge clock);
    bus.Rx = 13'(536); bus.Ry = '0; bus.validIn = 1'b1;
    @(posedge clock);
    #1 bus.validIn = 1'b0;
    repeat (30) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    read_r(r);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (r[i] !== 0) begin failures++; $display("FAIL midrst_%s actual=%0d expected=0", nm[i], r[i]); end
    end
    checks++;
    if (bus.readyIn !== 1'b1) begin failures++; $display("FAIL midrst_readyIn actual=%b expected=1", bus.readyIn); end
    reset = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      @(negedge clock);
      if (bus.validOut) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL midrst_no_validOut actual=%b expected=0", seen); end
    checks++;
    if (bus.readyIn !== 1'b1) begin failures++; $display("FAIL midrst_idle actual=%b expected=1", bus.readyIn); end
    e = '{56761, 0, -32759, 0, 65536, 0, 32759, 0, 56761};
    run_one(0, -536, lat);
    checks++;
    if (lat !== 69) begin failures++; $display("FAIL midrst_latency actual=%0d expected=69", lat); end
    read_r(r);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (r[i] < e[i] - TOL || r[i] > e[i] + TOL) begin
        failures++; $display("FAIL midrst_after_%s actual=%0d expected=%0d+-%0d", nm[i], r[i], e[i], TOL);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero();
    test_rx();
    test_ry();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
